sram_64x32_arbiter: RTL

//  Shares one single-port sram_64x32 macro between two requesters (port A, port B).
//  - Zero-fills the array after reset, then arbitrates requests round-robin.
//  - Drives the macro's ce/we/addr/wd/mask pins.
//  - Returns read data one cycle after each read is granted.
//  - Sits between the core-side memory clients and the hard SRAM in the sky130hd flow.

---
 rtl/sram_64x32_arbiter_if.sv | 58 +++++
 rtl/sram_64x32_arbiter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/sram_64x32_arbiter_if.sv
// sram_64x32_arbiter_if: bundles the two requester ports, the init status flag and the
// single-port SRAM macro pins.
//   slave  modport : the arbiter (consumes requests, drives responses and macro pins)
//   master modport : the surrounding logic (requesters plus macro)
//   a_req_* / b_req_*  request valid/ready/we/addr/wdata/wmask
//   a_rsp_* / b_rsp_*  response valid pulse and read data
//   sram_*             macro ce/we/addr/wd/wmask pins and the rd return bus
interface sram_64x32_arbiter_if #(
  parameter int unsigned BITS       = 32,
  parameter int unsigned ADDR_WIDTH = 6
) ();
  logic                  init_done;

  logic                  a_req_valid;
  logic                  a_req_ready;
  logic                  a_req_we;
  logic [ADDR_WIDTH-1:0] a_req_addr;
  logic [BITS-1:0]       a_req_wdata;
  logic [BITS-1:0]       a_req_wmask;
  logic                  a_rsp_valid;
  logic [BITS-1:0]       a_rsp_rdata;

  logic                  b_req_valid;
  logic                  b_req_ready;
  logic                  b_req_we;
  logic [ADDR_WIDTH-1:0] b_req_addr;
  logic [BITS-1:0]       b_req_wdata;
  logic [BITS-1:0]       b_req_wmask;
  logic                  b_rsp_valid;
  logic [BITS-1:0]       b_rsp_rdata;

  logic                  sram_ce;
  logic                  sram_we;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [BITS-1:0]       sram_wd;
  logic [BITS-1:0]       sram_wmask;
  logic [BITS-1:0]       sram_rd;

  modport slave (
    output init_done,
    input  a_req_valid, a_req_we, a_req_addr, a_req_wdata, a_req_wmask,
    output a_req_ready, a_rsp_valid, a_rsp_rdata,
    input  b_req_valid, b_req_we, b_req_addr, b_req_wdata, b_req_wmask,
    output b_req_ready, b_rsp_valid, b_rsp_rdata,
    output sram_ce, sram_we, sram_addr, sram_wd, sram_wmask,
    input  sram_rd
  );

  modport master (
    input  init_done,
    output a_req_valid, a_req_we, a_req_addr, a_req_wdata, a_req_wmask,
    input  a_req_ready, a_rsp_valid, a_rsp_rdata,
    output b_req_valid, b_req_we, b_req_addr, b_req_wdata, b_req_wmask,
    input  b_req_ready, b_rsp_valid, b_rsp_rdata,
    input  sram_ce, sram_we, sram_addr, sram_wd, sram_wmask,
    output sram_rd
  );
endinterface

// File: rtl/sram_64x32_arbiter.sv
// sram_64x32_arbiter: shares one single-port 64x32 SRAM macro between requesters A and B.
// After reset the array is zero-filled (one word per cycle), then requests are granted
// round-robin, one access per cycle, with a fixed one-cycle response.
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   io_bus   : request/response ports for A and B, init_done, and the macro pins
module sram_64x32_arbiter #(
  parameter int unsigned BITS       = 32,
  parameter int unsigned WORD_DEPTH = 64,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter bit          INIT_ZERO  = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  sram_64x32_arbiter_if.slave     io_bus
);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  localparam state_e              ResetState = INIT_ZERO ? StInit : StRun;
  localparam logic [ADDR_WIDTH:0] LastWord   = (ADDR_WIDTH + 1)'(WORD_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] CntOne     = (ADDR_WIDTH + 1)'(1);

  state_e              r_state, w_state_next;
  // One bit wider than the address so the final count never wraps to 0.
  logic [ADDR_WIDTH:0] r_init_cnt, w_init_cnt_next;
  // 0: A has priority on a tie, 1: B has priority.
  logic                r_rr_ptr, w_rr_ptr_next;
  logic                w_gnt_a, w_gnt_b;

  logic                r_a_rd_pend, r_a_wr_pend, r_b_rd_pend, r_b_wr_pend;
  logic [BITS-1:0]     r_a_hold, r_b_hold;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ResetState;
      r_init_cnt <= '0;
      r_rr_ptr   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_init_cnt <= w_init_cnt_next;
      r_rr_ptr   <= w_rr_ptr_next;
    end
  end

  // Every output is forced low while reset is held, including the INIT macro drive.
  always_comb begin
    w_state_next      = r_state;
    w_init_cnt_next   = r_init_cnt;
    w_rr_ptr_next     = r_rr_ptr;
    w_gnt_a           = 1'b0;
    w_gnt_b           = 1'b0;
    io_bus.init_done  = 1'b0;
    io_bus.sram_ce    = 1'b0;
    io_bus.sram_we    = 1'b0;
    io_bus.sram_addr  = '0;
    io_bus.sram_wd    = '0;
    io_bus.sram_wmask = '0;
    if (i_rst_n) begin
      case (r_state)
        StInit: begin
          io_bus.sram_ce    = 1'b1;
          io_bus.sram_we    = 1'b1;
          io_bus.sram_addr  = r_init_cnt[ADDR_WIDTH-1:0];
          io_bus.sram_wmask = '1;
          w_init_cnt_next   = r_init_cnt + CntOne;
          if (r_init_cnt == LastWord) begin
            w_state_next = StRun;
          end
        end
        StRun: begin
          io_bus.init_done = 1'b1;
          w_gnt_a = io_bus.a_req_valid && (!io_bus.b_req_valid || !r_rr_ptr);
          w_gnt_b = io_bus.b_req_valid && (!io_bus.a_req_valid ||  r_rr_ptr);
          io_bus.sram_ce = w_gnt_a || w_gnt_b;
          // Pins are don't-care without a grant, so A's payload is the idle default.
          if (w_gnt_b) begin
            io_bus.sram_we    = io_bus.b_req_we;
            io_bus.sram_addr  = io_bus.b_req_addr;
            io_bus.sram_wd    = io_bus.b_req_wdata;
            io_bus.sram_wmask = io_bus.b_req_wmask;
          end else begin
            io_bus.sram_we    = io_bus.a_req_we;
            io_bus.sram_addr  = io_bus.a_req_addr;
            io_bus.sram_wd    = io_bus.a_req_wdata;
            io_bus.sram_wmask = io_bus.a_req_wmask;
          end
          if (w_gnt_a) begin
            w_rr_ptr_next = 1'b1;
          end else if (w_gnt_b) begin
            w_rr_ptr_next = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign io_bus.a_req_ready = w_gnt_a;
  assign io_bus.b_req_ready = w_gnt_b;

  // Remember what kind of access each port was granted; the macro returns read data
  // in the following cycle, which is also the response cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a_rd_pend <= 1'b0;
      r_a_wr_pend <= 1'b0;
      r_b_rd_pend <= 1'b0;
      r_b_wr_pend <= 1'b0;
      r_a_hold    <= '0;
      r_b_hold    <= '0;
    end else begin
      r_a_rd_pend <= w_gnt_a && !io_bus.a_req_we;
      r_a_wr_pend <= w_gnt_a &&  io_bus.a_req_we;
      r_b_rd_pend <= w_gnt_b && !io_bus.b_req_we;
      r_b_wr_pend <= w_gnt_b &&  io_bus.b_req_we;
      if (r_a_rd_pend) begin
        r_a_hold <= io_bus.sram_rd;
      end else if (r_a_wr_pend) begin
        r_a_hold <= '0;
      end
      if (r_b_rd_pend) begin
        r_b_hold <= io_bus.sram_rd;
      end else if (r_b_wr_pend) begin
        r_b_hold <= '0;
      end
    end
  end

  assign io_bus.a_rsp_valid = r_a_rd_pend || r_a_wr_pend;
  assign io_bus.b_rsp_valid = r_b_rd_pend || r_b_wr_pend;
  assign io_bus.a_rsp_rdata = r_a_rd_pend ? io_bus.sram_rd : (r_a_wr_pend ? '0 : r_a_hold);
  assign io_bus.b_rsp_rdata = r_b_rd_pend ? io_bus.sram_rd : (r_b_wr_pend ? '0 : r_b_hold);

endmodule
